// File: rtl/comparator_serial_nbit.sv
// Serial N-bit magnitude comparator: one DIGIT-bit slice per clock,
// MSB slice first, early exit on the first differing slice.
module comparator_serial_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0]    LAST = IW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic             r_arm;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [2:0]       r_flags;
    logic             r_busy;
    logic             r_done;

    logic [DIGIT-1:0] w_sa;
    logic [DIGIT-1:0] w_sb;
    logic             w_differ;
    logic             w_decide;
    logic             w_cmp;

    // Operands shift left each cycle, so the live slice is always on top.
    assign w_sa     = r_a[WIDTH-1 -: DIGIT];
    assign w_sb     = r_b[WIDTH-1 -: DIGIT];
    assign w_differ = (w_sa != w_sb);
    assign w_cmp    = (r_state == COMPARE);
    assign w_decide = w_cmp && !r_arm && (w_differ || (r_idx == LAST));

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE, DONE: w_state_n = start ? COMPARE : IDLE;
            COMPARE:    if (w_decide) w_state_n = DONE;
            default:    w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_arm   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_flags <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_busy  <= w_cmp && !w_decide;
            r_done  <= w_decide;
            if (!w_cmp) begin
                if (start) begin
                    // MSB flip maps two's-complement order onto unsigned order.
                    r_a     <= a ^ (signed_mode ? MSB : '0);
                    r_b     <= b ^ (signed_mode ? MSB : '0);
                    r_idx   <= '0;
                    r_flags <= 3'b000;
                    r_arm   <= 1'b1;
                end
            end else if (r_arm) begin
                r_arm <= 1'b0;
            end else if (w_decide) begin
                if (w_differ)
                    r_flags <= (w_sa > w_sb) ? 3'b100 : 3'b001;
                else
                    r_flags <= 3'b010;
            end else begin
                r_a   <= r_a << DIGIT;
                r_b   <= r_b << DIGIT;
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign gt   = r_flags[2];
    assign eq   = r_flags[1];
    assign lt   = r_flags[0];

endmodule

// File: tb/tb_comparator_serial_nbit.sv
// Randomised self-checking bench: DIGIT=1 and DIGIT=4 instances
// against an arithmetic reference model.
module tb_comparator_serial_nbit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st8 = 0, sm8 = 0, st4 = 0, sm4 = 0;
    logic [7:0] a8 = 0, b8 = 0, a4 = 0, b4 = 0;
    logic       busy8, done8, gt8, eq8, lt8;
    logic       busy4, done4, gt4, eq4, lt4;

    int checks = 0;
    int errors = 0;

    comparator_serial_nbit #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(st8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
        .gt(gt8), .eq(eq8), .lt(lt8)
    );

    comparator_serial_nbit #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4),
        .gt(gt4), .eq(eq4), .lt(lt4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // {busy, done, gt, eq, lt}
    function automatic logic [4:0] obs(input bit d);
        return d ? {busy4, done4, gt4, eq4, lt4}
                 : {busy8, done8, gt8, eq8, lt8};
    endfunction

    task automatic drive(input bit d, input logic st, input logic sm,
                         input logic [7:0] av, input logic [7:0] bv);
        if (d) begin st4 = st; sm4 = sm; a4 = av; b4 = bv; end
        else   begin st8 = st; sm8 = sm; a8 = av; b8 = bv; end
    endtask

    // Result from integer compare; latency from the first differing slice.
    task automatic model(input bit d, input logic [7:0] av,
                         input logic [7:0] bv, input bit sm,
                         output logic [2:0] f, output int lat);
        int dg = d ? 4 : 1;
        int ns = 8 / dg;
        int va = sm ? int'($signed(av)) : int'(av);
        int vb = sm ? int'($signed(bv)) : int'(bv);
        int k  = ns - 1;
        f = (va > vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
        for (int i = ns - 1; i >= 0; i--) begin
            int sh = 8 - (i + 1) * dg;
            if (((int'(av) >> sh) % (1 << dg)) != ((int'(bv) >> sh) % (1 << dg)))
                k = i;
        end
        lat = k + 2;
    endtask

    task automatic do_op(input bit d, input logic [7:0] av,
                         input logic [7:0] bv, input bit sm, input bit poke);
        logic [2:0] ef;
        logic [4:0] o;
        int lat, n, nb;
        model(d, av, bv, sm, ef, lat);
        n = 0;
        nb = 0;
        @(negedge clk);
        drive(d, 1'b1, sm, av, bv);
        @(posedge clk); #1;
        drive(d, 1'b0, $urandom_range(0, 1), 8'($urandom), 8'($urandom));
        o = obs(d);
        check("accept", {27'd0, o}, 32'h0);
        for (int e = 1; e <= 20; e++) begin
            if (poke && e == 2)
                drive(d, 1'b1, ~sm, ~av, bv ^ 8'h5A);
            @(posedge clk); #1;
            if (poke && e == 2)
                drive(d, 1'b0, sm, av, bv);
            o = obs(d);
            if (o[4]) nb++;
            if (o[3]) begin n = e; break; end
        end
        check("latency", n, lat);
        check("flags", {29'd0, o[2:0]}, {29'd0, ef});
        check("busycyc", nb, lat - 1);
        @(posedge clk); #1;
        o = obs(d);
        check("donepulse", {27'd0, o}, {27'd0, 2'b00, ef});
    endtask

    initial begin
        logic [4:0] o;
        logic [7:0] ra, rb;
        int nd, seen;

        #1;
        check("rst8", {27'd0, obs(0)}, 32'h0);
        check("rst4", {27'd0, obs(1)}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-compare
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'h5A, 8'h5A);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 8'h5A, 8'h5A);
        repeat (4) @(posedge clk);
        #1;
        check("midbusy", {31'd0, busy8}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst", {27'd0, obs(0)}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (obs(0) != 5'b0) nd++;
        end
        check("postrst", nd, 0);

        // Directed cases
        do_op(0, 8'h80, 8'h7F, 1'b0, 1'b0);
        do_op(0, 8'h80, 8'h7F, 1'b1, 1'b0);
        do_op(0, 8'hFF, 8'hFE, 1'b1, 1'b0);
        do_op(0, 8'h5A, 8'h5A, 1'b0, 1'b0);
        do_op(0, 8'h01, 8'h03, 1'b0, 1'b0);
        do_op(1, 8'h3C, 8'h3D, 1'b0, 1'b0);
        do_op(1, 8'hA0, 8'h9F, 1'b0, 1'b0);
        do_op(0, 8'h5A, 8'h5A, 1'b0, 1'b1);

        // Random, biased toward long shared prefixes
        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ 8'(1 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            do_op(i[0], ra, rb, 1'($urandom), 1'($urandom));
        end

        // Start held high through DONE
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'h80, 8'h7F);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 8'h5A, 8'h5A);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b2b_done1", {27'd0, obs(0)}, 32'b01100);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'hFF);
        check("b2b_accept", {27'd0, obs(0)}, 32'h0);
        seen = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            o = obs(0);
            if (e == 1) check("b2b_busy", {31'd0, o[4]}, 32'd1);
            if (o[3]) begin seen = e; break; end
            if (o[2:0] != 3'b000) check("b2b_hold", {29'd0, o[2:0]}, 32'h0);
        end
        check("b2b_lat", seen, 9);
        check("b2b_eq", {29'd0, o[2:0]}, 32'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
